// File: rtl/rams_pkg.sv
// Shared encodings for the single-port byte-enable RAM and its clear sequencer.
package rams_pkg;

   // Read-during-write behaviour selector values.
   localparam int RD_FIRST  = 0;
   localparam int WR_FIRST  = 1;
   localparam int NO_CHANGE = 2;

   // Clear sequencer states.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/rams_clr_seq.sv
// Clear sequencer: sweeps every address once, writing zero, on reset or on a clr pulse.
module rams_clr_seq
   import rams_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   output logic              swp_we,
   output logic [ADDR_W-1:0] swp_addr
);

   // One extra bit so the counter cannot wrap before the last address is written.
   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

   clr_state_t      state;
   logic [ADDR_W:0] cnt;

   // Sweep FSM; busy is registered alongside the state so it tracks CLEAR exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         state <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
         busy  <= (CLEAR_ON_RST != 0);
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign swp_we   = (state == CLEAR);
   assign swp_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/rams_sp_be_clr.sv
// Single-port block RAM with column write enables, selectable read-during-write,
// optional output register, data-valid strobe and a hardware zero-fill sweep.
module rams_sp_be_clr
   import rams_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int COL_W        = 8,
   parameter int ADDR_W       = 10,
   parameter int RD_MODE      = RD_FIRST,
   parameter int OUT_REG      = 1,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [DATA_W/COL_W-1:0]  we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        di,
   input  logic                     clr,
   output logic                     busy,
   output logic [DATA_W-1:0]        dout,
   output logic                     dout_vld
);

   localparam int NB_COL = DATA_W / COL_W;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              swp_we;
   logic [ADDR_W-1:0] swp_addr;
   logic              usr_acc;
   logic              usr_wr;
   logic              rd_launch;
   logic [DATA_W-1:0] wr_word;
   logic [DATA_W-1:0] rd_q;
   logic [STAGES:1]   vld_q;
   logic [STAGES:0]   vld_pipe;

   rams_clr_seq #(
      .ADDR_W       (ADDR_W),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .busy     (busy),
      .swp_we   (swp_we),
      .swp_addr (swp_addr)
   );

   // User traffic is locked out while sweeping and during reset.
   assign usr_acc   = en & ~busy & ~rst;
   assign usr_wr    = usr_acc & (|we);
   assign rd_launch = usr_acc & ~((RD_MODE == NO_CHANGE) & (|we));

   // Merged word for write-first: new columns where enabled, stored data elsewhere.
   always_comb begin
      wr_word = mem[addr];
      for (int c = 0; c < NB_COL; c++) begin
         if (we[c]) wr_word[c*COL_W +: COL_W] = di[c*COL_W +: COL_W];
      end
   end

   // Array write port: sweep zero-fill has priority, else column-masked user write.
   always_ff @(posedge clk) begin
      if (swp_we) begin
         mem[swp_addr] <= '0;
      end else if (usr_wr) begin
         for (int c = 0; c < NB_COL; c++) begin
            if (we[c]) mem[addr][c*COL_W +: COL_W] <= di[c*COL_W +: COL_W];
         end
      end
   end

   // First read stage; only loads on a launched read so it holds between reads.
   always_ff @(posedge clk) begin
      if (rst)            rd_q <= '0;
      else if (rd_launch) rd_q <= (RD_MODE == WR_FIRST) ? wr_word : mem[addr];
   end

   // Valid strobe follows the launch flag through the same number of stages as data.
   assign vld_pipe = {vld_q, rd_launch};
   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_pipe[STAGES-1:0];
   end

   assign dout_vld = vld_pipe[STAGES];

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] out_q;
         // Output register captures only valid read data so dout holds otherwise.
         always_ff @(posedge clk) begin
            if (rst)              out_q <= '0;
            else if (vld_pipe[1]) out_q <= rd_q;
         end
         assign dout = out_q;
      end else begin : g_noreg
         assign dout = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_rams_sp_be_clr.sv
// Directed bench: four RAM variants share stimulus, each checked against hand values.
// u0 read-first/OUT_REG=1, u1 write-first/OUT_REG=0, u2 no-change/OUT_REG=1,
// u3 read-first/OUT_REG=1 with CLEAR_ON_RST=0.
module tb_rams_sp_be_clr;

   logic        clk = 1'b0;
   logic        rst, en, clr;
   logic [1:0]  we;
   logic [9:0]  addr;
   logic [15:0] di;
   logic [15:0] d0, d1, d2, d3;
   logic        v0, v1, v2, v3;
   logic        b0, b1, b2, b3;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   rams_sp_be_clr #(.RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(1)) u0 (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
      .busy(b0), .dout(d0), .dout_vld(v0));
   rams_sp_be_clr #(.RD_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
      .busy(b1), .dout(d1), .dout_vld(v1));
   rams_sp_be_clr #(.RD_MODE(2), .OUT_REG(1), .CLEAR_ON_RST(1)) u2 (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
      .busy(b2), .dout(d2), .dout_vld(v2));
   rams_sp_be_clr #(.RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(0)) u3 (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
      .busy(b3), .dout(d3), .dout_vld(v3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [1:0] w, input logic [15:0] d);
      en = 1'b1; we = w; addr = a; di = d;
      tick();
      en = 1'b0; we = 2'b00;
   endtask

   task automatic rd(input logic [9:0] a);
      en = 1'b1; we = 2'b00; addr = a;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset;
      int c;
      rst = 1'b1; en = 1'b0; we = 2'b00; addr = '0; di = '0; clr = 1'b0;
      tick();
      rst = 1'b0;
      n_cmp++; if (d0 !== 16'h0000) begin n_err++; $display("FAIL rst_d0 got=%h exp=0000", d0); end
      n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL rst_v0 got=%b exp=0", v0); end
      n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL rst_busy0 got=%b exp=1", b0); end
      n_cmp++; if (b3 !== 1'b0) begin n_err++; $display("FAIL rst_busy3 got=%b exp=0", b3); end
      n_cmp++; if ({v3, d3} !== 17'h0) begin n_err++; $display("FAIL rst_u3_out got=%b/%h exp=0/0000", v3, d3); end
      c = 0;
      while (b0 && c < 2000) begin c++; tick(); end
      n_cmp++; if (c != 1024) begin n_err++; $display("FAIL rst_sweep_len got=%0d exp=1024", c); end
      n_cmp++; if ({b1, b2} !== 2'b00) begin n_err++; $display("FAIL rst_busy12 got=%b exp=00", {b1, b2}); end
   endtask

   task automatic test_read_cleared;
      rd(10'h3FF);
      n_cmp++; if ({v1, d1} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL clr_rd_u1 got=%b/%h exp=1/0000", v1, d1); end
      n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL clr_rd_v0_early got=%b exp=0", v0); end
      tick();
      n_cmp++; if ({v0, d0} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL clr_rd_u0 got=%b/%h exp=1/0000", v0, d0); end
      n_cmp++; if ({v2, d2} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL clr_rd_u2 got=%b/%h exp=1/0000", v2, d2); end
      tick();
      n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL clr_rd_v0_late got=%b exp=0", v0); end
   endtask

   task automatic test_byte_we;
      wr(10'd5, 2'b11, 16'hABCD);
      wr(10'd5, 2'b01, 16'h1234);
      tick(); tick(); tick();
      rd(10'd5);
      n_cmp++; if ({v1, d1} !== {1'b1, 16'hAB34}) begin n_err++; $display("FAIL bwe_u1 got=%b/%h exp=1/ab34", v1, d1); end
      tick();
      n_cmp++; if ({v0, d0} !== {1'b1, 16'hAB34}) begin n_err++; $display("FAIL bwe_u0 got=%b/%h exp=1/ab34", v0, d0); end
      n_cmp++; if ({v2, d2} !== {1'b1, 16'hAB34}) begin n_err++; $display("FAIL bwe_u2 got=%b/%h exp=1/ab34", v2, d2); end
      tick();
   endtask

   task automatic test_rdw_modes;
      wr(10'd7, 2'b11, 16'hAAAA);
      tick(); tick(); tick();
      wr(10'd7, 2'b11, 16'h5555);
      n_cmp++; if ({v1, d1} !== {1'b1, 16'h5555}) begin n_err++; $display("FAIL rdw_wrfirst got=%b/%h exp=1/5555", v1, d1); end
      n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rdw_nochg_v_early got=%b exp=0", v2); end
      tick();
      n_cmp++; if ({v0, d0} !== {1'b1, 16'hAAAA}) begin n_err++; $display("FAIL rdw_rdfirst got=%b/%h exp=1/aaaa", v0, d0); end
      n_cmp++; if ({v2, d2} !== {1'b0, 16'hAB34}) begin n_err++; $display("FAIL rdw_nochg got=%b/%h exp=0/ab34", v2, d2); end
      tick();
      rd(10'd7);
      tick();
      n_cmp++; if ({v2, d2} !== {1'b1, 16'h5555}) begin n_err++; $display("FAIL rdw_stored got=%b/%h exp=1/5555", v2, d2); end
      tick();
   endtask

   task automatic test_clr_inflight;
      int c;
      logic sawv;
      rd(10'd5);
      clr = 1'b1;
      n_cmp++; if ({v1, d1} !== {1'b1, 16'hAB34}) begin n_err++; $display("FAIL infl_u1 got=%b/%h exp=1/ab34", v1, d1); end
      tick();
      clr = 1'b0;
      n_cmp++; if ({v0, d0} !== {1'b1, 16'hAB34}) begin n_err++; $display("FAIL infl_u0 got=%b/%h exp=1/ab34", v0, d0); end
      n_cmp++; if ({v2, d2} !== {1'b1, 16'hAB34}) begin n_err++; $display("FAIL infl_u2 got=%b/%h exp=1/ab34", v2, d2); end
      n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL infl_busy got=%b exp=1", b0); end
      c = 0; sawv = 1'b0;
      while (b0 && c < 2000) begin
         en   = (c >= 100 && c < 103);
         we   = en ? 2'b11 : 2'b00;
         addr = 10'd5;
         di   = 16'hFFFF;
         clr  = (c == 200);
         c++;
         tick();
         if (v0 | v1 | v2) sawv = 1'b1;
      end
      en = 1'b0; we = 2'b00; clr = 1'b0;
      n_cmp++; if (c != 1024) begin n_err++; $display("FAIL infl_sweep_len got=%0d exp=1024", c); end
      n_cmp++; if (sawv !== 1'b0) begin n_err++; $display("FAIL infl_vld_busy got=%b exp=0", sawv); end
      rd(10'd5);
      n_cmp++; if ({v1, d1} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL infl_postclr_u1 got=%b/%h exp=1/0000", v1, d1); end
      tick();
      n_cmp++; if ({v0, d0} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL infl_postclr_u0 got=%b/%h exp=1/0000", v0, d0); end
      tick();
   endtask

   task automatic test_rst_mid_sweep;
      int c;
      wr(10'd7, 2'b11, 16'h1111);
      tick(); tick();
      rd(10'd7);
      tick(); tick();
      n_cmp++; if ({d0, d1, d2} !== {16'h1111, 16'h1111, 16'h1111}) begin n_err++; $display("FAIL rmid_pre got=%h/%h/%h exp=1111 x3", d0, d1, d2); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (500) tick();
      n_cmp++; if ({b0, b3} !== 2'b11) begin n_err++; $display("FAIL rmid_busy_pre got=%b exp=11", {b0, b3}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if ({v0, d0} !== 17'h0) begin n_err++; $display("FAIL rmid_u0 got=%b/%h exp=0/0000", v0, d0); end
      n_cmp++; if ({v1, d1, d2} !== 33'h0) begin n_err++; $display("FAIL rmid_u12 got=%b/%h/%h exp=0/0000/0000", v1, d1, d2); end
      n_cmp++; if ({b0, b3} !== 2'b10) begin n_err++; $display("FAIL rmid_busy_post got=%b exp=10", {b0, b3}); end
      c = 0;
      while (b0 && c < 2000) begin c++; tick(); end
      n_cmp++; if (c != 1024) begin n_err++; $display("FAIL rmid_sweep_len got=%0d exp=1024", c); end
   endtask

   task automatic test_back_to_back;
      wr(10'd1, 2'b11, 16'h1001);
      wr(10'd2, 2'b11, 16'h2002);
      wr(10'd3, 2'b11, 16'h3003);
      tick(); tick();
      en = 1'b1; we = 2'b00; addr = 10'd1;
      tick();
      n_cmp++; if ({v1, d1} !== {1'b1, 16'h1001}) begin n_err++; $display("FAIL b2b_r1 got=%b/%h exp=1/1001", v1, d1); end
      addr = 10'd2;
      tick();
      n_cmp++; if ({v1, d1} !== {1'b1, 16'h2002}) begin n_err++; $display("FAIL b2b_r2 got=%b/%h exp=1/2002", v1, d1); end
      n_cmp++; if ({v0, d0} !== {1'b1, 16'h1001}) begin n_err++; $display("FAIL b2b_u0_r1 got=%b/%h exp=1/1001", v0, d0); end
      addr = 10'd3;
      tick();
      en = 1'b0;
      n_cmp++; if ({v1, d1} !== {1'b1, 16'h3003}) begin n_err++; $display("FAIL b2b_r3 got=%b/%h exp=1/3003", v1, d1); end
      n_cmp++; if ({v0, d0} !== {1'b1, 16'h2002}) begin n_err++; $display("FAIL b2b_u0_r2 got=%b/%h exp=1/2002", v0, d0); end
      tick();
      n_cmp++; if ({v1, d1} !== {1'b0, 16'h3003}) begin n_err++; $display("FAIL b2b_hold got=%b/%h exp=0/3003", v1, d1); end
      n_cmp++; if ({v0, d0} !== {1'b1, 16'h3003}) begin n_err++; $display("FAIL b2b_u0_r3 got=%b/%h exp=1/3003", v0, d0); end
      tick();
      n_cmp++; if ({v0, d0} !== {1'b0, 16'h3003}) begin n_err++; $display("FAIL b2b_u0_hold got=%b/%h exp=0/3003", v0, d0); end
   endtask

   initial begin
      test_reset();
      test_read_cleared();
      test_byte_we();
      test_rdw_modes();
      test_clr_inflight();
      test_rst_mid_sweep();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
